// File: rtl/sif_pkg.sv
// Shared SIF bus constants and write-driver state encoding.
package sif_pkg;

  localparam int SIF_ADDR_W = 16;
  localparam int SIF_DATA_W = 16;

  // Level of wa_wr_s that marks an active write strobe.
  localparam logic ENABLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } w_drv_state_t;

endpackage

// File: rtl/sif_req_fifo.sv
// Synchronous request FIFO with wrap-bit pointers; the storage array is not reset.
module sif_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sif_w_driver.sv
// SIF write-channel initiator: buffers requests and drives SETUP/STROBE/HOLD write cycles.
// Optional SIF_W_DRV_STATS_EN adds saturating completed/aborted write counters.
module sif_w_driver
  import sif_pkg::*;
#(
  parameter int ADDR_W     = SIF_ADDR_W,
  parameter int DATA_W     = SIF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter int WAIT_MAX   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] wa_addr,
  output logic [DATA_W-1:0] wa_data_wr,
  output logic              wa_wr_s,
  input  logic              wa_wait,
  output logic              busy,
  output logic              err_timeout
`ifdef SIF_W_DRV_STATS_EN
  ,
  output logic [15:0]       wr_done_cnt,
  output logic [7:0]        wr_abort_cnt
`endif
);

  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);
  localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP_CYCLES - 1);

  w_drv_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              err_q, err_d;
  logic              init_q;
  logic              pop, done, abort;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_rdata;

  sif_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_valid && req_ready),
    .pop_i   (pop),
    .wdata_i ({req_addr, req_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop              = 1'b1;
          {addr_d, data_d} = fifo_rdata;
          state_d          = SETUP;
        end
      end
      SETUP: begin
        wait_cnt_d = '0;
        state_d    = STROBE;
      end
      STROBE: begin
        // Abort only once WAIT_MAX stall edges have already been absorbed.
        if (!wa_wait) begin
          done = 1'b1;
        end else if (wait_cnt_q == WAIT_LIM) begin
          abort = 1'b1;
          err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
        if (done || abort) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
      init_q     <= 1'b1;
    end
  end

  // Strobe decodes straight from the state flop so an async reset drops it at once.
  assign wa_wr_s     = (state_q == STROBE) & ENABLE;
  assign wa_addr     = addr_q;
  assign wa_data_wr  = data_q;
  assign req_ready   = init_q && !fifo_full;
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign err_timeout = err_q;

`ifdef SIF_W_DRV_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [15:0] done_cnt_q;
  logic [7:0]  abort_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (done)  done_cnt_q  <= sat_inc16(done_cnt_q);
      if (abort) abort_cnt_q <= sat_inc8(abort_cnt_q);
    end
  end

  assign wr_done_cnt  = done_cnt_q;
  assign wr_abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_sif_w_driver.sv
// Directed self-checking bench for sif_w_driver (default parameters, GAP=1, WAIT_MAX=8, DEPTH=4).
module tb_sif_w_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic [15:0] wa_addr;
  logic [15:0] wa_data_wr;
  logic        wa_wr_s;
  logic        wa_wait = 1'b0;
  logic        busy;
  logic        err_timeout;
`ifdef SIF_W_DRV_STATS_EN
  logic [15:0] wr_done_cnt;
  logic [7:0]  wr_abort_cnt;
`endif

  int errors = 0;
  int checks = 0;

  sif_w_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .wa_addr     (wa_addr),
    .wa_data_wr  (wa_data_wr),
    .wa_wr_s     (wa_wr_s),
    .wa_wait     (wa_wait),
    .busy        (busy),
    .err_timeout (err_timeout)
`ifdef SIF_W_DRV_STATS_EN
    ,
    .wr_done_cnt (wr_done_cnt),
    .wr_abort_cnt(wr_abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Passive observer of the write channel, sampled mid-cycle.
  logic        ws_prev = 1'b0;
  int          run_len = 0;
  int          last_width = 0;
  int          err_cnt = 0;
  int          stable_err = 0;
  logic [15:0] held_a = '0, held_d = '0;
  logic [15:0] mon_addr[$];
  logic [15:0] mon_data[$];

  always @(negedge clk) begin
    if (wa_wr_s) begin
      if (!ws_prev) begin
        mon_addr.push_back(wa_addr);
        mon_data.push_back(wa_data_wr);
        held_a  = wa_addr;
        held_d  = wa_data_wr;
        run_len = 1;
      end else begin
        run_len++;
        if (wa_addr !== held_a || wa_data_wr !== held_d) stable_err++;
      end
    end else if (ws_prev) begin
      last_width = run_len;
    end
    if (err_timeout) err_cnt++;
    ws_prev = wa_wr_s;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int n;

    // Reset state
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_s", 32'(wa_wr_s), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_addr", 32'(wa_addr), 32'd0);
    rst_n = 1'b1;
    chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    chk("rel_ready_after_edge", 32'(req_ready), 32'd1);

    // 1: single write, latency and strobe shape
    push(16'h00A5, 16'h1234);
    chk("t1_busy_queued", 32'(busy), 32'd1);
    chk("t1_wr_s_idle", 32'(wa_wr_s), 32'd0);
    tick();
    chk("t1_setup_wr_s", 32'(wa_wr_s), 32'd0);
    chk("t1_setup_addr", 32'(wa_addr), 32'h00A5);
    chk("t1_setup_data", 32'(wa_data_wr), 32'h1234);
    tick();
    chk("t1_strobe_wr_s", 32'(wa_wr_s), 32'd1);
    chk("t1_strobe_addr", 32'(wa_addr), 32'h00A5);
    tick();
    chk("t1_hold_wr_s", 32'(wa_wr_s), 32'd0);
    chk("t1_hold_addr", 32'(wa_addr), 32'h00A5);
    chk("t1_hold_data", 32'(wa_data_wr), 32'h1234);
    chk("t1_hold_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_addr", 32'(wa_addr), 32'h00A5);
    chk("t1_width", 32'(last_width), 32'd1);

    // 2: fill the FIFO behind a stalled write, overflow request waits for a pop
    base = mon_addr.size();
    wa_wait = 1'b1;
    for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i), 16'hD000 + 16'(i));
    chk("t2_full_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_addr  = 16'h0105;
    req_data  = 16'hD005;
    tick();
    chk("t2_still_full", 32'(req_ready), 32'd0);
    wa_wait = 1'b0;
    push(16'h0105, 16'hD005);
    drain();
    chk("t2_count", 32'(mon_addr.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < mon_addr.size()) begin
        chk("t2_order_addr", 32'(mon_addr[base + i]), 32'h0100 + 32'(i));
        chk("t2_order_data", 32'(mon_data[base + i]), 32'hD000 + 32'(i));
      end
    end
    chk("t2_no_err", 32'(err_cnt), 32'd0);

    // 3: three stall edges stretch the strobe to four cycles
    push(16'h0200, 16'hBEEF);
    wa_wait = 1'b1;
    n = 0;
    while (!wa_wr_s && n < 20) begin
      tick();
      n++;
    end
    chk("t3_strobe_seen", 32'(wa_wr_s), 32'd1);
    tick();
    tick();
    chk("t3_mid_data", 32'(wa_data_wr), 32'hBEEF);
    tick();
    wa_wait = 1'b0;
    drain();
    chk("t3_width", 32'(last_width), 32'd4);
    chk("t3_no_err", 32'(err_cnt), 32'd0);

    // 4: stuck stall aborts once, next queued entry still goes out
    base = mon_addr.size();
    wa_wait = 1'b1;
    push(16'h0300, 16'h1111);
    push(16'h0301, 16'h2222);
    n = 0;
    while (!err_timeout && n < 40) begin
      tick();
      n++;
    end
    chk("t4_err_pulse", 32'(err_timeout), 32'd1);
    tick();
    chk("t4_err_one_cycle", 32'(err_timeout), 32'd0);
    wa_wait = 1'b0;
    drain();
    chk("t4_err_count", 32'(err_cnt), 32'd1);
    chk("t4_count", 32'(mon_addr.size() - base), 32'd2);
    if (mon_addr.size() >= base + 2) begin
      chk("t4_first_addr", 32'(mon_addr[base]), 32'h0300);
      chk("t4_next_addr", 32'(mon_addr[base + 1]), 32'h0301);
      chk("t4_next_data", 32'(mon_data[base + 1]), 32'h2222);
    end
    chk("t4_next_width", 32'(last_width), 32'd1);
    chk("stable_during_strobe", 32'(stable_err), 32'd0);

    // 5: async reset in the middle of a strobe
    wa_wait = 1'b1;
    push(16'h0400, 16'h4444);
    push(16'h0401, 16'h5555);
    n = 0;
    while (!wa_wr_s && n < 20) begin
      tick();
      n++;
    end
    chk("t5_strobe_seen", 32'(wa_wr_s), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_wr_s_dropped", 32'(wa_wr_s), 32'd0);
    chk("t5_ready_low", 32'(req_ready), 32'd0);
    chk("t5_busy_low", 32'(busy), 32'd0);
    chk("t5_addr_cleared", 32'(wa_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    wa_wait = 1'b0;
    chk("t5_ready_at_release", 32'(req_ready), 32'd0);
    tick();
    chk("t5_ready_after", 32'(req_ready), 32'd1);
    tick();
    tick();
    chk("t5_fifo_empty", 32'(busy), 32'd0);
    chk("t5_no_strobe", 32'(wa_wr_s), 32'd0);

`ifdef SIF_W_DRV_STATS_EN
    // 6: statistics counters
    chk("t6_done_rst", 32'(wr_done_cnt), 32'd0);
    chk("t6_abort_rst", 32'(wr_abort_cnt), 32'd0);
    for (int i = 0; i < 3; i++) push(16'h0500 + 16'(i), 16'h6000 + 16'(i));
    drain();
    wa_wait = 1'b1;
    push(16'h0600, 16'h7777);
    n = 0;
    while (!err_timeout && n < 40) begin
      tick();
      n++;
    end
    chk("t6_err_pulse", 32'(err_timeout), 32'd1);
    wa_wait = 1'b0;
    drain();
    chk("t6_done_cnt", 32'(wr_done_cnt), 32'd3);
    chk("t6_abort_cnt", 32'(wr_abort_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
